// File: rtl/uioreg_con_arbiter_pkg.sv
// Shared types and constants for the con register bus arbiter.
// Holds the transaction state encoding and the default bus geometry.
package uioreg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int DEF_N_REQ         = 2;
  localparam int DEF_ADDRESS_WIDTH = 14;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_READ_LATENCY  = 1;

  // The latency counter only needs to reach READ_LATENCY-1 (max 6)
  localparam int CNT_W = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uioreg_rr_arbiter.sv
// Combinational round-robin selector: picks the first requester after last_grant.
// Produces both a one-hot grant and its binary index.
module uioreg_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] idx;

  // Scan from the farthest candidate to the nearest so the nearest set bit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % N);
      if (req[idx]) begin
        grant     = N'(1) << idx;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/uioreg_con_arbiter.sv
// Shares the con register bus between N_REQ requesters with round-robin
// arbitration, one transaction at a time, and fixed-latency read capture.
module uioreg_con_arbiter
  import uioreg_pkg::*;
#(
  parameter int N_REQ         = DEF_N_REQ,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int READ_LATENCY  = DEF_READ_LATENCY
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ-1:0]                req_write,
  input  logic [N_REQ*ADDRESS_WIDTH-1:0]  req_address,
  input  logic [N_REQ*DATA_WIDTH-1:0]     req_writedata,
  output logic [N_REQ-1:0]                req_ready,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_readdata,
  output logic [ADDRESS_WIDTH-1:0]        con_adrout,
  output logic [DATA_WIDTH-1:0]           con_dataout,
  input  logic [DATA_WIDTH-1:0]           con_datain,
  output logic                            con_write_out,
  output logic                            con_read_out,
  output logic                            con_chip_sel,
  output logic                            busy
);

  localparam int IW = idx_w(N_REQ);

  state_t state, state_nx;

  logic [IW-1:0]            gnt_idx_q;
  logic                     wr_q;
  logic [IW-1:0]            last_grant_q;
  logic [CNT_W-1:0]         wcnt_q;
  logic [N_REQ-1:0]         arb_grant;
  logic [IW-1:0]            arb_idx;
  logic                     grant_load;
  logic                     capture;
  logic [ADDRESS_WIDTH-1:0] addr_arr [N_REQ];
  logic [DATA_WIDTH-1:0]    data_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i] = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      data_arr[i] = req_writedata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  uioreg_rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      gnt_idx_q    <= '0;
      wr_q         <= 1'b0;
      last_grant_q <= IW'(N_REQ - 1);
      wcnt_q       <= '0;
      con_adrout   <= '0;
      con_dataout  <= '0;
      rsp_valid    <= '0;
      rsp_readdata <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= '0;
      if (grant_load) begin
        gnt_idx_q    <= arb_idx;
        wr_q         <= |(arb_grant & req_write);
        last_grant_q <= arb_idx;
        con_adrout   <= addr_arr[arb_idx];
        con_dataout  <= data_arr[arb_idx];
      end
      if (state == ISSUE) begin
        wcnt_q <= CNT_W'(1);
      end else if (state == WAIT) begin
        wcnt_q <= wcnt_q + 1'b1;
      end
      // Registered response: the pulse overlaps the next IDLE decision
      if (capture) begin
        rsp_valid    <= N_REQ'(1) << gnt_idx_q;
        rsp_readdata <= con_datain;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    grant_load    = 1'b0;
    capture       = 1'b0;
    con_chip_sel  = 1'b0;
    con_write_out = 1'b0;
    con_read_out  = 1'b0;
    req_ready     = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_load = 1'b1;
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        con_chip_sel  = 1'b1;
        con_write_out = wr_q;
        con_read_out  = !wr_q;
        req_ready     = N_REQ'(1) << gnt_idx_q;
        if (wr_q) begin
          state_nx = IDLE;
        end else if (READ_LATENCY > 1) begin
          state_nx = WAIT;
        end else begin
          state_nx = CAPTURE;
        end
      end
      WAIT: begin
        con_chip_sel = 1'b1;
        if (wcnt_q == CNT_W'(READ_LATENCY - 1)) begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        con_chip_sel = 1'b1;
        capture      = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uioreg_con_arbiter.sv
// Directed bench for uioreg_con_arbiter: one instance with READ_LATENCY=1 and
// one with READ_LATENCY=3 share the same requester and con_datain stimulus.
module tb_uioreg_con_arbiter;

  localparam int N  = 2;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_address;
  logic [N*DW-1:0]   req_writedata;
  logic [DW-1:0]     con_datain;

  logic [N-1:0]  ready1, rspv1, ready3, rspv3;
  logic [DW-1:0] rdata1, dout1, rdata3, dout3;
  logic [AW-1:0] adr1, adr3;
  logic          wr1, rd1, cs1, busy1, wr3, rd3, cs3, busy3;

  int n_cmp = 0;
  int n_bad = 0;

  uioreg_con_arbiter #(.N_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_writedata(req_writedata), .req_ready(ready1),
    .rsp_valid(rspv1), .rsp_readdata(rdata1), .con_adrout(adr1), .con_dataout(dout1),
    .con_datain(con_datain), .con_write_out(wr1), .con_read_out(rd1),
    .con_chip_sel(cs1), .busy(busy1)
  );

  uioreg_con_arbiter #(.N_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_writedata(req_writedata), .req_ready(ready3),
    .rsp_valid(rspv3), .rsp_readdata(rdata3), .con_adrout(adr3), .con_dataout(dout3),
    .con_datain(con_datain), .con_write_out(wr3), .con_read_out(rd3),
    .con_chip_sel(cs3), .busy(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    req_valid     = '0;
    req_write     = '0;
    req_address   = '0;
    req_writedata = '0;
    con_datain    = '0;
    repeat (2) tick();
    n_cmp++;
    if ({busy1, cs1, wr1, rd1, ready1, rspv1, adr1, dout1, rdata1} !== '0) begin
      n_bad++;
      $display("FAIL reset_dut1: got busy=%b cs=%b wr=%b rd=%b rdy=%b rspv=%b adr=%h dout=%h rdata=%h want all 0",
               busy1, cs1, wr1, rd1, ready1, rspv1, adr1, dout1, rdata1);
    end
    n_cmp++;
    if ({busy3, cs3, wr3, rd3, ready3, rspv3, adr3, dout3, rdata3} !== '0) begin
      n_bad++;
      $display("FAIL reset_dut3: got busy=%b cs=%b wr=%b rd=%b rdy=%b rspv=%b adr=%h dout=%h rdata=%h want all 0",
               busy3, cs3, wr3, rd3, ready3, rspv3, adr3, dout3, rdata3);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({busy1, busy3, cs1, cs3} !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy1=%b busy3=%b cs1=%b cs3=%b want 0000", busy1, busy3, cs1, cs3);
    end
  endtask

  task automatic test_single_write();
    req_address[0 +: AW]   = 14'h0123;
    req_writedata[0 +: DW] = 32'hDEADBEEF;
    req_write = 2'b01;
    req_valid = 2'b01;
    tick();
    n_cmp++;
    if ({cs1, wr1, rd1} !== 3'b110) begin
      n_bad++;
      $display("FAIL wr_strobes: got cs/wr/rd=%b want 110", {cs1, wr1, rd1});
    end
    n_cmp++;
    if (adr1 !== 14'h0123 || dout1 !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL wr_bus: got adr=%h dout=%h want 0123 deadbeef", adr1, dout1);
    end
    n_cmp++;
    if ({ready1, ready3, busy1} !== 5'b01011) begin
      n_bad++;
      $display("FAIL wr_ready: got rdy1=%b rdy3=%b busy=%b want 01 01 1", ready1, ready3, busy1);
    end
    req_valid = '0;
    tick();
    n_cmp++;
    if ({busy1, busy3, cs1, wr1, rd1, ready1, rspv1, rspv3} !== '0) begin
      n_bad++;
      $display("FAIL wr_done: got busy1=%b busy3=%b cs=%b wr=%b rd=%b rdy=%b rspv1=%b rspv3=%b want all 0",
               busy1, busy3, cs1, wr1, rd1, ready1, rspv1, rspv3);
    end
    tick();
    n_cmp++;
    if ({rspv1, rspv3} !== 4'b0000) begin
      n_bad++;
      $display("FAIL wr_no_rsp: got rspv1=%b rspv3=%b want 00 00", rspv1, rspv3);
    end
  endtask

  task automatic test_single_read();
    req_address[AW +: AW] = 14'h0040;
    req_write  = 2'b00;
    req_valid  = 2'b10;
    con_datain = 32'h00000055;
    tick();
    n_cmp++;
    if ({cs1, wr1, rd1, ready1} !== 5'b10110 || adr1 !== 14'h0040) begin
      n_bad++;
      $display("FAIL rd_issue: got cs/wr/rd=%b rdy=%b adr=%h want 101 10 0040", {cs1, wr1, rd1}, ready1, adr1);
    end
    n_cmp++;
    if ({wr3, rd3} !== 2'b01) begin
      n_bad++;
      $display("FAIL rd_issue_l3: got wr/rd=%b want 01", {wr3, rd3});
    end
    req_valid = '0;
    tick();
    n_cmp++;
    if ({rd1, rspv1, busy1} !== 4'b0001) begin
      n_bad++;
      $display("FAIL rd_capture: got rd=%b rspv=%b busy=%b want 0 00 1", rd1, rspv1, busy1);
    end
    tick();
    n_cmp++;
    if (rspv1 !== 2'b10 || rdata1 !== 32'h00000055 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_rsp: got rspv=%b rdata=%h busy=%b want 10 00000055 0", rspv1, rdata1, busy1);
    end
    tick();
    n_cmp++;
    if (rspv1 !== 2'b00 || rdata1 !== 32'h00000055 || rspv3 !== 2'b00) begin
      n_bad++;
      $display("FAIL rd_rsp_hold: got rspv1=%b rdata1=%h rspv3=%b want 00 00000055 00", rspv1, rdata1, rspv3);
    end
    tick();
    n_cmp++;
    if (rspv3 !== 2'b10 || rdata3 !== 32'h00000055) begin
      n_bad++;
      $display("FAIL rd_rsp_l3: got rspv=%b rdata=%h want 10 00000055", rspv3, rdata3);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0]  exp_rdy;
    logic [AW-1:0] exp_adr;
    req_valid = '0;
    reset_n   = 1'b0;
    tick();
    req_address[0 +: AW]    = 14'h0100;
    req_address[AW +: AW]   = 14'h0200;
    req_writedata[0 +: DW]  = 32'h0000000A;
    req_writedata[DW +: DW] = 32'h0000000B;
    req_write = 2'b11;
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_adr = (k % 2 == 0) ? 14'h0100 : 14'h0200;
      tick();
      n_cmp++;
      if (ready1 !== exp_rdy || ready3 !== exp_rdy || adr1 !== exp_adr || wr1 !== 1'b1) begin
        n_bad++;
        $display("FAIL contend_%0d: got rdy1=%b rdy3=%b adr=%h wr=%b want %b %b %h 1",
                 k, ready1, ready3, adr1, wr1, exp_rdy, exp_rdy, exp_adr);
      end
      tick();
      n_cmp++;
      if ({ready1, ready3, cs1} !== 5'b00000) begin
        n_bad++;
        $display("FAIL contend_gap_%0d: got rdy1=%b rdy3=%b cs=%b want 00 00 0", k, ready1, ready3, cs1);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_latency3();
    req_address[0 +: AW] = 14'h0010;
    req_write  = 2'b00;
    req_valid  = 2'b01;
    con_datain = 32'hA0000000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      con_datain = 32'hA0000000 + k;
      if (k == 1) begin
        n_cmp++;
        if ({cs3, rd3, wr3} !== 3'b110 || adr3 !== 14'h0010) begin
          n_bad++;
          $display("FAIL l3_issue: got cs/rd/wr=%b adr=%h want 110 0010", {cs3, rd3, wr3}, adr3);
        end
        req_valid = '0;
      end else if (k == 2 || k == 3) begin
        n_cmp++;
        if ({cs3, rd3, wr3, busy3} !== 4'b1001) begin
          n_bad++;
          $display("FAIL l3_wait_%0d: got cs/rd/wr/busy=%b want 1001", k, {cs3, rd3, wr3, busy3});
        end
      end else if (k == 4) begin
        n_cmp++;
        if (rspv3 !== 2'b00 || busy3 !== 1'b1) begin
          n_bad++;
          $display("FAIL l3_capture: got rspv=%b busy=%b want 00 1", rspv3, busy3);
        end
      end else begin
        n_cmp++;
        if (rspv3 !== 2'b01 || rdata3 !== 32'hA0000004) begin
          n_bad++;
          $display("FAIL l3_rsp: got rspv=%b rdata=%h want 01 a0000004", rspv3, rdata3);
        end
        n_cmp++;
        if (rdata1 !== 32'hA0000002) begin
          n_bad++;
          $display("FAIL l1_rdata: got %h want a0000002", rdata1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [N-1:0] seen;
    req_address[0 +: AW] = 14'h0020;
    req_write  = 2'b00;
    req_valid  = 2'b01;
    con_datain = 32'h12345678;
    tick();
    req_valid = '0;
    tick();
    n_cmp++;
    if ({busy3, cs3} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_pre: got busy3=%b cs3=%b want 11", busy3, cs3);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy3, cs3, wr3, rd3, ready3, rspv3, adr3, dout3, rdata3} !== '0) begin
      n_bad++;
      $display("FAIL mid_async_dut3: got busy=%b cs=%b rdy=%b rspv=%b adr=%h dout=%h rdata=%h want all 0",
               busy3, cs3, ready3, rspv3, adr3, dout3, rdata3);
    end
    n_cmp++;
    if ({busy1, cs1, wr1, rd1, ready1, rspv1, adr1, dout1, rdata1} !== '0) begin
      n_bad++;
      $display("FAIL mid_async_dut1: got busy=%b cs=%b rdy=%b rspv=%b adr=%h dout=%h rdata=%h want all 0",
               busy1, cs1, ready1, rspv1, adr1, dout1, rdata1);
    end
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    seen = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | rspv1 | rspv3;
    end
    n_cmp++;
    if (seen !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_no_rsp: got rspv accumulated=%b want 00", seen);
    end
    req_write = 2'b11;
    req_valid = 2'b11;
    tick();
    n_cmp++;
    if (ready1 !== 2'b01 || ready3 !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_first_grant: got rdy1=%b rdy3=%b want 01 01", ready1, ready3);
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_latency3();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uioreg_con_arbiter.md
Name: uioreg_con_arbiter

Overview:
- Shares the single custom "con" register bus (address, write data, read data, write/read/chip-select strobes) between N_REQ internal requesters. Examples are the HPS-side register bridge and the synth engine's parameter loader.
- Round-robin arbitration, one transaction in flight at a time.
- Fixed-latency read capture and per-requester response strobes.
- Sits between the requesters and the con register file / voice parameter RAM.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- ADDRESS_WIDTH, 14, con bus address width
- DATA_WIDTH, 32, con bus data width
- READ_LATENCY, 1, cycles from con_read_out assertion to valid con_datain (1..7)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- req_valid  in  N_REQ  per-requester request; held until req_ready
- req_write  in  N_REQ  1 = write, 0 = read
- req_address  in  N_REQ*ADDRESS_WIDTH  packed addresses, requester i at [i*AW +: AW]
- req_writedata  in  N_REQ*DATA_WIDTH  packed write data
- req_ready  out  N_REQ  one-cycle accept pulse, one-hot
- rsp_valid  out  N_REQ  one-cycle read-data pulse, one-hot
- rsp_readdata  out  DATA_WIDTH  read data, shared, valid while rsp_valid
- con_adrout  out  ADDRESS_WIDTH  con bus address
- con_dataout  out  DATA_WIDTH  con bus write data
- con_datain  in  DATA_WIDTH  con bus read data
- con_write_out  out  1  write strobe
- con_read_out  out  1  read strobe
- con_chip_sel  out  1  con bus select
- busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; state IDLE.
  - last_grant = N_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction aborts it. No req_ready or rsp_valid is produced for the aborted transaction.
- States: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - If any req_valid bit is set, grant g = first set bit searching last_grant+1, +2, … modulo N_REQ.
  - Register req_address[g] and req_writedata[g] to con_adrout/con_dataout.
  - Latch g and req_write[g]; set last_grant = g; go to ISSUE.
  - With no request: outputs stay idle, con_adrout/con_dataout hold their last values.
- ISSUE (exactly 1 cycle):
  - con_chip_sel = 1; con_write_out = write flag; con_read_out = !write flag.
  - req_ready[g] = 1.
  - Write → IDLE.
  - Read → WAIT if READ_LATENCY > 1, else CAPTURE.
- WAIT:
  - Counter runs from 1 to READ_LATENCY-1; strobes are 0, chip_sel stays 1.
  - Go to CAPTURE when the count completes.
- CAPTURE:
  - Sample con_datain into rsp_readdata; go to IDLE.
  - rsp_valid[g] = 1 for the following cycle (registered).
  - rsp_readdata holds until the next capture.
- Throughput:
  - write: 2 cycles per transaction.
  - read: READ_LATENCY+2 cycles per transaction.
  - The IDLE decision overlaps the rsp_valid pulse of the previous read.
- Requester rules:
  - Fields must stay stable until req_ready.
  - req_valid may drop before grant; the arbiter samples only in IDLE.
  - A request deasserted in the grant cycle is still executed.
- Simultaneous requests: strict rotation. Every pending requester is served within N_REQ transactions (no starvation).
- Exactly one of con_write_out/con_read_out is asserted per transaction; never both.

Decomposition:
- Package uioreg_pkg:
  - state enum (IDLE, ISSUE, WAIT, CAPTURE)
  - default width constants
  - clog2-based index width for N_REQ
- Sub-module uioreg_rr_arbiter:
  - combinational round-robin select from req vector and last_grant
  - outputs one-hot grant and binary index
  - reused elsewhere for voice-slot sharing

Test Plan:
- Single write: req0 write, addr 0x0123, data 0xDEADBEEF.
  - Next cycle: con_write_out=1, con_chip_sel=1, con_adrout=0x0123, con_dataout=0xDEADBEEF, req_ready=2'b01.
  - busy low 2 cycles after grant.
- Single read, READ_LATENCY=1: req1 read, addr 0x0040, con_datain=0x00000055.
  - con_read_out pulses once, then rsp_valid=2'b10 with rsp_readdata=0x00000055.
  - No rsp_valid on writes.
- Contention: req0 and req1 both continuously write.
  - Grants alternate 0,1,0,1 starting with 0 after reset; each req_ready is one-hot.
- READ_LATENCY=3: read 0x0010 while con_datain changes each cycle.
  - Captured value equals con_datain 3 cycles after the con_read_out cycle.
  - Chip-select stays high through WAIT.
- Reset mid-read: assert reset_n=0 during WAIT.
  - All outputs 0 immediately (async), with no rsp_valid after release.
  - The next request is granted to requester 0 first.
